// File: rtl/div_remainder_reg.sv
// div_remainder_reg: 2*WIDTH-bit remainder/quotient register for the
// restoring divider. The upper half holds the partial remainder. The lower
// half starts with the dividend, which shifts out while quotient bits shift
// in at the LSB.
// Optional build macro REMAINDER_PRESHIFT_EN: the idle load writes the
// dividend already shifted left by one, so the controller skips its first
// left shift.
module div_remainder_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               rdy,
  input  logic               w_ctrl_reg2,
  input  logic               SLL_ctrl,
  input  logic               SRL_ctrl,
  input  logic [WIDTH-1:0]   reg2_in,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  output logic [2*WIDTH-1:0] reg2_out,
  output logic [WIDTH-1:0]   hi
);

  logic [2*WIDTH-1:0] r_q;
  logic [2*WIDTH-1:0] r_d;
  logic [2*WIDTH-1:0] load_val;
  logic [WIDTH-1:0]   hn;
  logic               q_bit;

  // The quotient bit is 1 only on a write with no borrow. Without that, the
  // old remainder is restored rather than taking the ALU difference.
  assign q_bit = w_ctrl_reg2 & alu_carry;
  assign hn    = q_bit ? alu_result : r_q[2*WIDTH-1:WIDTH];

`ifdef REMAINDER_PRESHIFT_EN
  assign load_val = {{(WIDTH-1){1'b0}}, reg2_in, 1'b0};
`else
  assign load_val = {{WIDTH{1'b0}}, reg2_in};
`endif

  // Next-state selection: idle load, then freeze, then left shift, then
  // right shift, then plain write-back.
  always_comb begin
    r_d = r_q;
    if (!run) begin
      if (w_ctrl_reg2) r_d = load_val;
    end else if (rdy) begin
      r_d = r_q;
    end else if (SLL_ctrl) begin
      // The top bit of hn falls off. The dividend/quotient half shifts up,
      // and the quotient bit enters at the LSB.
      r_d = {hn[WIDTH-2:0], r_q[WIDTH-1:0], q_bit};
    end else if (SRL_ctrl) begin
      r_d = {1'b0, r_q[2*WIDTH-1:WIDTH+1], r_q[WIDTH-1:0]};
    end else begin
      r_d = {hn, r_q[WIDTH-1:0]};
    end
  end

  // The register itself. Reset clears it at once, regardless of the clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= '0;
    else      r_q <= r_d;
  end

  assign reg2_out = r_q;
  assign hi       = r_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_div_remainder_reg.sv
// Self-checking bench for div_remainder_reg. It acts as the divider
// controller and the ALU, and checks the results against plain arithmetic.
module tb_div_remainder_reg;

`ifdef REMAINDER_PRESHIFT_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        run, rdy, w_ctrl_reg2, SLL_ctrl, SRL_ctrl;
  logic [31:0] reg2_in, alu_result;
  logic        alu_carry;
  logic [63:0] reg2_out;
  logic [31:0] hi;

  // The ALU model either tracks hi - divisor, or is forced by the bench.
  logic [31:0] divisor;
  logic        ovr;
  logic [31:0] ovr_res;
  logic        ovr_c;

  int n_chk  = 0;
  int n_fail = 0;

  div_remainder_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .run(run), .rdy(rdy), .w_ctrl_reg2(w_ctrl_reg2),
    .SLL_ctrl(SLL_ctrl), .SRL_ctrl(SRL_ctrl), .reg2_in(reg2_in),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .reg2_out(reg2_out), .hi(hi)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = ovr ? ovr_res : hi - divisor;
    alu_carry  = ovr ? ovr_c   : (hi >= divisor);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load d, then apply k plain left shifts with no write (gives d << (k+PRE)).
  task automatic load_shift(input logic [31:0] d, input int k);
    run = 1'b0; rdy = 1'b0; w_ctrl_reg2 = 1'b1; SLL_ctrl = 1'b0; SRL_ctrl = 1'b0;
    reg2_in = d;
    step();
    run = 1'b1; w_ctrl_reg2 = 1'b0; SLL_ctrl = 1'b1;
    repeat (k) step();
    SLL_ctrl = 1'b0;
  endtask

  // Full division as the controller would sequence it. If abort_at is
  // non-negative, reset is pulsed between edges during that step.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int abort_at);
    logic [31:0] eq, er;
    ovr = 1'b0; divisor = b;
    run = 1'b0; rdy = 1'b0; w_ctrl_reg2 = 1'b1; SLL_ctrl = 1'b0; SRL_ctrl = 1'b0;
    reg2_in = a;
    step();
    run = 1'b1;
    if (PRE == 0) begin
      w_ctrl_reg2 = 1'b0; SLL_ctrl = 1'b1;
      step();
    end
    w_ctrl_reg2 = 1'b1; SLL_ctrl = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) begin
        #2 rst = 1'b0;
        #1 check("abort_async_r", reg2_out, 64'h0);
        check("abort_async_hi", {32'h0, hi}, 64'h0);
        step();
        check("abort_held_r", reg2_out, 64'h0);
        #2 rst = 1'b1;
        run = 1'b0; w_ctrl_reg2 = 1'b0; SLL_ctrl = 1'b0;
        return;
      end
      step();
    end
    w_ctrl_reg2 = 1'b0; SLL_ctrl = 1'b0; SRL_ctrl = 1'b1;
    step();
    SRL_ctrl = 1'b0; rdy = 1'b1;
    step();
    eq = a / b;
    er = a % b;
    check($sformatf("div_rem %h/%h", a, b), {32'h0, hi}, {32'h0, er});
    check($sformatf("div_quo %h/%h", a, b), {32'h0, reg2_out[31:0]}, {32'h0, eq});
    rdy = 1'b0; run = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b0; run = 1'b0; rdy = 1'b0; w_ctrl_reg2 = 1'b1;
    SLL_ctrl = 1'b0; SRL_ctrl = 1'b0; reg2_in = 32'h1000_0000;
    divisor = 32'h1; ovr = 1'b0; ovr_res = '0; ovr_c = 1'b0;

    // Reset held while a load is requested.
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_r", reg2_out, 64'h0);
      check("reset_hi", {32'h0, hi}, 64'h0);
      step();
    end
    #3 rst = 1'b1;
    #1 check("reset_release_r", reg2_out, 64'h0);
    step();
    check("load_r", reg2_out, 64'h1000_0000 << PRE);
    check("load_hi", {32'h0, hi}, 64'h0);

    // Directed divisions.
    do_div(32'd7, 32'd2, -1);
    do_div(32'hFFFF_FFFF, 32'h10, -1);

    // Restore vs ALU write on a combined shift.
    load_shift(32'h5, 32 - PRE);
    check("setup_5_0", reg2_out, {32'h5, 32'h0});
    ovr = 1'b1; ovr_res = 32'h1234_5678; ovr_c = 1'b0;
    w_ctrl_reg2 = 1'b1; SLL_ctrl = 1'b1;
    step();
    check("restore", reg2_out, {32'hA, 32'h0});
    SLL_ctrl = 1'b0;
    load_shift(32'h5, 32 - PRE);
    ovr = 1'b1; ovr_c = 1'b1; w_ctrl_reg2 = 1'b1; SLL_ctrl = 1'b1;
    step();
    check("alu_write", reg2_out, {32'h2468_ACF0, 32'h1});
    SLL_ctrl = 1'b0; w_ctrl_reg2 = 1'b0; ovr = 1'b0;

    // A right shift moves hi only.
    load_shift(32'hD, 31 - PRE);
    check("setup_6_8", reg2_out, {32'h6, 32'h8000_0000});
    SRL_ctrl = 1'b1;
    step();
    check("srl", reg2_out, {32'h3, 32'h8000_0000});

    // With both shifts requested, the left shift wins.
    SLL_ctrl = 1'b1; SRL_ctrl = 1'b1;
    step();
    check("sll_wins", reg2_out, {32'h7, 32'h0});
    SLL_ctrl = 1'b0; SRL_ctrl = 1'b0;

    // Freeze when rdy is high, under changing controls.
    rdy = 1'b1; ovr = 1'b1; ovr_res = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      ovr_c = i[0]; SRL_ctrl = i[1]; w_ctrl_reg2 = i[2]; SLL_ctrl = i[0] ^ i[1];
      step();
      check("freeze", reg2_out, {32'h7, 32'h0});
    end
    rdy = 1'b0; run = 1'b0; ovr = 1'b0; SRL_ctrl = 1'b0; SLL_ctrl = 1'b0; w_ctrl_reg2 = 1'b0;

    // Asynchronous reset mid-division, then a clean rerun.
    do_div(32'd7, 32'd2, 10);
    do_div(32'd7, 32'd2, -1);

    // Random divisions. The divisor stays below 2^31, so the shifted
    // remainder never loses its top bit.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom_range(32'h7FFF_FFFF, 1);
      if (i == 0) rb = 32'h1;
      do_div(ra, rb, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_remainder_reg.md
Name: div_remainder_reg

Overview:
- 64-bit remainder/quotient register for the team's unsigned, multi-cycle, restoring divider.
- Upper half (hi) holds the partial remainder; lower half holds the dividend, which shifts out while quotient bits shift in.
- Driven by the divider control FSM (`run`, `rdy`, `w_ctrl_reg2`, `SLL_ctrl`, `SRL_ctrl`) and by the external 32-bit ALU, which computes hi minus divisor.
- Final state: hi = remainder, lo = quotient.

Parameters:
- WIDTH, 32, operand width; the register is 2*WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (named rst per codebase convention; 0 = reset asserted)
- run  input  1  1 = division in progress; 0 = idle/load phase
- rdy  input  1  1 = division complete; register freezes
- w_ctrl_reg2  input  1  write enable (load when idle; ALU write-back/quotient insert when running)
- SLL_ctrl  input  1  shift whole register left by 1
- SRL_ctrl  input  1  shift hi half right by 1 (final correction)
- reg2_in  input  32  dividend
- alu_result  input  32  hi minus divisor, from the ALU
- alu_carry  input  1  1 = no borrow (hi >= divisor)
- reg2_out  output  64  full register R[63:0]
- hi  output  32  R[63:32], combinational from R

Behaviour:
- State is a single 64-bit register R. Both outputs are continuous views of R and add no latency.
- Reset: `rst`=0 forces R=0 immediately, independent of `clk`. Reset has top priority, including mid-division. After `rst` deasserts, R stays 0 until the next qualifying write.
- Define hn = alu_result when (`w_ctrl_reg2` & `alu_carry`), otherwise hn = R[63:32] (restore).
- Define q = `w_ctrl_reg2` & `alu_carry`.
- Priority at each rising edge, with `rst`=1:
  1. `run`=0: if `w_ctrl_reg2`, R <= {32'h0, reg2_in}; else hold. All shift controls are ignored.
  2. `run`=1 and `rdy`=1: hold. Everything else is ignored.
  3. `run`=1, `rdy`=0, `SLL_ctrl`=1: R <= {hn[30:0], R[31:0], q}. This is a combined write-back plus shift, with the quotient bit entering at the LSB. `SLL_ctrl` wins over `SRL_ctrl` when both are high.
  4. `run`=1, `rdy`=0, `SRL_ctrl`=1: R <= {1'b0, R[63:33], R[31:0]}. Only hi shifts; lo is unchanged.
  5. `run`=1, `rdy`=0, no shift: R[63:32] <= hn; lo is held.
- `alu_carry` is don't-care unless `w_ctrl_reg2`=1.
- `alu_result` is never written without `alu_carry`=1; this is the restore rule.
- Width rules:
  - Logical shifts only; zero fill.
  - The bit shifted out of R[63] is discarded.
  - No sign handling.
- Expected controller sequence (informative):
  - Load.
  - One initial SLL with `w_ctrl_reg2`=0.
  - 32 steps of SLL with `w_ctrl_reg2`=1.
  - One SRL.
  - Then `rdy`.
- Outputs change only at a clock edge or on reset assertion; no glitch paths from inputs to outputs.

Optional Feature:
- Macro: REMAINDER_PRESHIFT_EN.
- Defined: the idle load writes R <= {31'h0, reg2_in, 1'b0}, folding the initial left shift into the load. The controller then omits the first SLL.
- Undefined: the load writes {32'h0, reg2_in} as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold `rst`=0 with `reg2_in`=32'h10000000, `w_ctrl_reg2`=1 and clock toggling → `reg2_out`=64'h0 and `hi`=0 throughout. Release `rst` mid-cycle → R stays 0 until the next edge.
- Load: `run`=0, `w_ctrl_reg2`=1, `reg2_in`=32'h10000000 → `reg2_out`=64'h0000_0000_1000_0000 and `hi`=0.
- Full division: dividend 7, divisor 2, bench models ALU as hi-2 with carry=(hi>=2), sequence run as described → final `hi`=1, `reg2_out[31:0]`=3. Repeat with 32'hFFFFFFFF / 32'h10 → `hi`=32'hF, lo=32'h0FFFFFFF.
- Restore vs write: set R={32'h5,32'h0}, `run`=1, `w_ctrl_reg2`=1, `SLL_ctrl`=1, `alu_result`=32'h12345678.
  - `alu_carry`=0 → R={32'hA,32'h0}.
  - `alu_carry`=1 → R={32'h2468ACF0,32'h1}.
- Priority/freeze:
  - `SLL_ctrl`=`SRL_ctrl`=1 → left shift only.
  - `rdy`=1 while toggling `alu_carry`, `SRL_ctrl` and `w_ctrl_reg2` every few cycles → R unchanged.
  - `SRL_ctrl` alone on hi=32'h6 → hi=32'h3 and lo unchanged.
- Async reset mid-operation: assert `rst`=0 between clock edges during step 10 of a division → R=0 immediately. Reload and rerun 7/2 → same result as a clean run.
